dram_dma: RTL

//  Block-transfer engine between external DRAM and the processor's local image memory.
//  On a load request it copies the input image DRAM->local memory and pulses rd_done.
//  On a store request it copies the downsampled result local->DRAM and pulses wr_done.

---
 rtl/dram_dma_pkg.sv | 7 +
 rtl/dram_dma_copy_pipe.sv | 35 +++
 rtl/dram_dma.sv | 85 ++++++++
 3 files changed

// File: rtl/dram_dma_pkg.sv
// dram_dma_pkg: shared state/direction encodings and width defaults for the DRAM DMA engine
package dram_dma_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, LOAD, L_TAIL, DONE_L, STORE, S_TAIL, DONE_S} state_t;
  typedef enum logic {DIR_LOAD, DIR_STORE} dir_t;
endpackage

// File: rtl/dram_dma_copy_pipe.sv
// dram_dma_copy_pipe: word counter plus one-stage delayed write address/valid, direction-agnostic
//  clk, reset      clock, async active-high reset
//  run             count while high; counter returns to 0 when low
//  n_m1            index of the last word (N-1)
//  rd_addr         read-side address (counter)
//  last            counter is at the last word
//  wr_addr         write-side address (counter delayed one cycle, 0 when idle)
//  wr_valid        write-side strobe (run delayed one cycle)
module dram_dma_copy_pipe #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] n_m1,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid
);
  logic [ADDR_W-1:0] cnt;
  assign rd_addr = cnt;
  // terminating on compare with N-1 lets N = 2**ADDR_W run through all-ones without wrapping
  assign last = cnt == n_m1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt      <= '0;
      wr_addr  <= '0;
      wr_valid <= 1'b0;
    end else begin
      cnt      <= run && !last ? cnt + 1'b1 : '0;
      wr_addr  <= run ? cnt : '0;
      wr_valid <= run;
    end
endmodule

// File: rtl/dram_dma.sv
// dram_dma: block copy DRAM->local on rd_en rise (rd_done) and local->DRAM on wr_en rise (wr_done)
//  clk, reset                       clock, async active-high reset
//  rd_en, wr_en                     load/store requests, rising edge starts a transfer in IDLE
//  rd_done, wr_done                 one-cycle completion pulses
//  busy                             high while a transfer is in progress (incl. tail)
//  ext_addr/ext_we/ext_wdata/ext_rdata  DRAM port, sync read
//  loc_addr/loc_we/loc_wdata/loc_rdata  local memory port, sync read
module dram_dma import dram_dma_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IN_WORDS  = 65536,
  parameter int OUT_WORDS = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  output logic              rd_done,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ext_addr,
  output logic              ext_we,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] loc_addr,
  output logic              loc_we,
  output logic [DATA_W-1:0] loc_wdata,
  input  logic [DATA_W-1:0] loc_rdata
);
  localparam logic [ADDR_W-1:0] IN_LAST  = ADDR_W'(IN_WORDS - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_WORDS - 1);
  state_t state, state_n;
  dir_t dir;
  logic rd_prev, wr_prev, rd_rise, wr_rise;
  logic run, last, wr_valid, is_load, is_store;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  assign rd_rise = rd_en && !rd_prev;
  assign wr_rise = wr_en && !wr_prev;
  assign run = state == LOAD || state == STORE;
  assign dir = state == STORE || state == S_TAIL ? DIR_STORE : DIR_LOAD;
  assign busy = run || state == L_TAIL || state == S_TAIL;
  assign is_load = busy && dir == DIR_LOAD;
  assign is_store = busy && dir == DIR_STORE;
  dram_dma_copy_pipe #(.ADDR_W(ADDR_W)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .n_m1    (dir == DIR_STORE ? OUT_LAST : IN_LAST),
    .rd_addr (rd_addr),
    .last    (last),
    .wr_addr (wr_addr),
    .wr_valid(wr_valid)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
    end else begin
      state   <= state_n;
      rd_prev <= rd_en;
      wr_prev <= wr_en;
    end
  // load has priority when both requests rise together; edges outside IDLE are ignored
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rd_rise ? LOAD : wr_rise ? STORE : IDLE;
      LOAD:    state_n = last ? L_TAIL : LOAD;
      L_TAIL:  state_n = DONE_L;
      STORE:   state_n = last ? S_TAIL : STORE;
      S_TAIL:  state_n = DONE_S;
      default: state_n = IDLE;
    endcase
  end
  // the read side follows the counter, the write side follows its one-cycle-delayed copy
  assign ext_addr  = is_load ? rd_addr : is_store ? wr_addr : '0;
  assign loc_addr  = is_store ? rd_addr : is_load ? wr_addr : '0;
  assign loc_we    = is_load && wr_valid;
  assign ext_we    = is_store && wr_valid;
  assign loc_wdata = loc_we ? ext_rdata : '0;
  assign ext_wdata = ext_we ? loc_rdata : '0;
  assign rd_done   = state == DONE_L;
  assign wr_done   = state == DONE_S;
endmodule
